cla_arb_seq: RTL and testbench

CLA_ARB_SEQ -- requirements
Module: cla_arb_seq

---
 rtl/cla_arb_seq_if.sv | 46 ++++
 rtl/cla_arb_seq.sv | 132 +++++++++++++
 tb/tb_cla_arb_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cla_arb_seq_if.sv
// Bundles the two requester ports, the result port and the busy flag for the
// arbitrated, slice-serial carry-lookahead add/subtract unit.
interface cla_arb_seq_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_x;
  logic [W-1:0] req0_y;
  logic         req0_sub;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_x;
  logic [W-1:0] req1_y;
  logic         req1_sub;

  logic         res_valid;
  logic         res_ready;
  logic         res_id;
  logic [W-1:0] s;
  logic         Cout;
  logic         ovf;
  logic         zero;
  logic         busy;

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_sub,
    output req0_ready,
    input  req1_valid, req1_x, req1_y, req1_sub,
    output req1_ready,
    input  res_ready,
    output res_valid, res_id, s, Cout, ovf, zero, busy
  );

  modport master (
    output req0_valid, req0_x, req0_y, req0_sub,
    input  req0_ready,
    output req1_valid, req1_x, req1_y, req1_sub,
    input  req1_ready,
    output res_ready,
    input  res_valid, res_id, s, Cout, ovf, zero, busy
  );
endinterface

// File: rtl/cla_arb_seq.sv
// Two-requester round-robin arbiter feeding a 4-bit-per-cycle carry-lookahead
// adder/subtractor; result held in DONE until the consumer accepts it.
module cla_arb_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  cla_arb_seq_if.slave bus
);
  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        r_state;
  logic          r_rr;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic          r_sub;
  logic          r_id;
  logic [IW-1:0] r_idx;
  logic          r_c;
  logic [W-1:0]  r_s;
  logic          r_cout;
  logic          r_ovf;
  logic          r_zero;
  logic          r_valid;
  logic          r_busy;

  logic          w_gnt0;
  logic          w_gnt1;
  logic [3:0]    w_xs;
  logic [3:0]    w_yb;
  logic [3:0]    w_g;
  logic [3:0]    w_p;
  logic [4:0]    w_c;
  logic [3:0]    w_sum;
  logic [W-1:0]  w_s_next;

  // Grant is gated by rst so no handshake can be seen during a reset cycle.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == IDLE && !rst) begin
      if (bus.req0_valid && (!bus.req1_valid || !r_rr)) w_gnt0 = 1'b1;
      else if (bus.req1_valid)                         w_gnt1 = 1'b1;
    end
  end

  always_comb begin
    w_xs  = r_x[{r_idx, 2'b00} +: 4];
    w_yb  = r_y[{r_idx, 2'b00} +: 4] ^ {4{r_sub}};
    w_g   = w_xs & w_yb;
    w_p   = w_xs | w_yb;
    w_c   = '0;
    w_c[0] = r_c;
    for (int unsigned k = 0; k < 4; k++) begin
      w_c[k+1] = w_g[k] | (w_p[k] & w_c[k]);
    end
    w_sum    = w_xs ^ w_yb ^ w_c[3:0];
    w_s_next = r_s;
    w_s_next[{r_idx, 2'b00} +: 4] = w_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_sub   <= 1'b0;
      r_id    <= 1'b0;
      r_idx   <= '0;
      r_c     <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_x     <= w_gnt1 ? bus.req1_x   : bus.req0_x;
            r_y     <= w_gnt1 ? bus.req1_y   : bus.req0_y;
            r_sub   <= w_gnt1 ? bus.req1_sub : bus.req0_sub;
            r_c     <= w_gnt1 ? bus.req1_sub : bus.req0_sub;
            r_id    <= w_gnt1;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_s <= w_s_next;
          r_c <= w_c[4];
          // On the top slice w_xs/w_yb/w_sum hold the sign bits of x, yb and s.
          if (r_idx == LAST) begin
            r_cout  <= w_c[4];
            r_ovf   <= (w_xs[3] == w_yb[3]) && (w_sum[3] != w_xs[3]);
            r_zero  <= (w_s_next == '0);
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_rr    <= ~r_id;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.res_valid  = r_valid;
  assign bus.res_id     = r_id;
  assign bus.s          = r_s;
  assign bus.Cout       = r_cout;
  assign bus.ovf        = r_ovf;
  assign bus.zero       = r_zero;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_cla_arb_seq.sv
// Directed bench for cla_arb_seq: table of single operations plus contention
// and mid-operation reset sequences.
module tb_cla_arb_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cla_arb_seq_if #(.NIBBLES(4)) bus ();

  cla_arb_seq #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          id;
    logic [15:0] x;
    logic [15:0] y;
    logic        sub;
    logic [15:0] es;
    logic        ec;
    logic        eo;
    logic        ez;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input logic v, input logic [15:0] x,
                         input logic [15:0] y, input logic sub);
    if (id == 1'b0) begin
      bus.req0_valid = v; bus.req0_x = x; bus.req0_y = y; bus.req0_sub = sub;
    end else begin
      bus.req1_valid = v; bus.req1_x = x; bus.req1_y = y; bus.req1_sub = sub;
    end
  endtask

  function automatic logic rdy(input bit id);
    return id ? bus.req1_ready : bus.req0_ready;
  endfunction

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.res_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'd4);
  endtask

  task automatic consume(input string name);
    bus.res_ready = 1'b1;
    #1;
    chk({name, "_rdy0_done"}, 32'(bus.req0_ready), 32'd0);
    chk({name, "_rdy1_done"}, 32'(bus.req1_ready), 32'd0);
    tick();
    bus.res_ready = 1'b0;
    chk({name, "_valid_after"}, 32'(bus.res_valid), 32'd0);
    chk({name, "_busy_after"},  32'(bus.busy),      32'd0);
  endtask

  task automatic run_op(input string name, input vec_t v);
    set_req(v.id, 1'b1, v.x, v.y, v.sub);
    set_req(~v.id, 1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    chk({name, "_ready"}, 32'(rdy(v.id)), 32'd1);
    chk({name, "_ready_other"}, 32'(rdy(~v.id)), 32'd0);
    tick();
    set_req(v.id, 1'b0, 16'($urandom()), 16'($urandom()), ~v.sub);
    wait_valid(name);
    chk({name, "_s"},    32'(bus.s),      32'(v.es));
    chk({name, "_cout"}, 32'(bus.Cout),   32'(v.ec));
    chk({name, "_ovf"},  32'(bus.ovf),    32'(v.eo));
    chk({name, "_zero"}, 32'(bus.zero),   32'(v.ez));
    chk({name, "_id"},   32'(bus.res_id), 32'(v.id));
    chk({name, "_busy"}, 32'(bus.busy),   32'd1);
    consume(name);
  endtask

  initial begin
    vec_t v;
    int   n;
    logic [15:0] held;
    bit   eid;
    checks = 0;
    errors = 0;

    vecs[0] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};

    // Reset with both requesters valid: no ready, all outputs cleared.
    rst = 1'b1;
    bus.res_ready = 1'b0;
    set_req(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0);
    set_req(1'b1, 1'b1, 16'h3333, 16'h4444, 1'b1);
    tick();
    tick();
    chk("rst_rdy0",  32'(bus.req0_ready), 32'd0);
    chk("rst_rdy1",  32'(bus.req1_ready), 32'd0);
    chk("rst_valid", 32'(bus.res_valid),  32'd0);
    chk("rst_busy",  32'(bus.busy),       32'd0);
    chk("rst_s",     32'(bus.s),          32'd0);
    chk("rst_flags", 32'({bus.Cout, bus.ovf, bus.zero, bus.res_id}), 32'd0);
    set_req(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    set_req(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Contention: both valid continuously from reset, grants alternate.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1'b0, 1'b1, 16'h0010, 16'h0001, 1'b0);
    set_req(1'b1, 1'b1, 16'h0020, 16'h0002, 1'b1);
    for (int k = 0; k < 4; k++) begin
      eid = bit'(k % 2);
      #1;
      n = 0;
      while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("cont%0d_wait", k), 32'(n < 20), 32'd1);
      chk($sformatf("cont%0d_grant", k), 32'(rdy(eid)), 32'd1);
      chk($sformatf("cont%0d_other", k), 32'(rdy(~eid)), 32'd0);
      tick();
      wait_valid($sformatf("cont%0d", k));
      chk($sformatf("cont%0d_id", k), 32'(bus.res_id), 32'(eid));
      chk($sformatf("cont%0d_s", k), 32'(bus.s), eid ? 32'h001E : 32'h0011);
      held = bus.s;
      for (int h = 0; h < 3; h++) begin
        tick();
        chk($sformatf("cont%0d_hold_valid", k), 32'(bus.res_valid), 32'd1);
        chk($sformatf("cont%0d_hold_s", k), 32'(bus.s), 32'(held));
        chk($sformatf("cont%0d_hold_rdy", k), 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      end
      consume($sformatf("cont%0d", k));
    end
    set_req(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    set_req(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);

    // Abort: leave rr=1, start a req0 op, reset in its 2nd CALC cycle.
    v = '{1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
    run_op("pre_abort", v);
    set_req(1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
    #1;
    chk("abort_accept", 32'(bus.req0_ready), 32'd1);
    tick();
    set_req(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    set_req(1'b1, 1'b1, 16'h0005, 16'h0003, 1'b1);
    tick();
    chk("abort_busy_calc", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rdy_in_rst", 32'(bus.req1_ready), 32'd0);
    tick();
    rst = 1'b0;
    chk("abort_valid", 32'(bus.res_valid), 32'd0);
    chk("abort_busy",  32'(bus.busy),      32'd0);
    chk("abort_s",     32'(bus.s),         32'd0);
    chk("abort_flags", 32'({bus.Cout, bus.ovf, bus.zero, bus.res_id}), 32'd0);
    set_req(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0);
    #1;
    chk("abort_rr_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("abort_rr_rdy1", 32'(bus.req1_ready), 32'd0);
    set_req(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    chk("abort_req1_rdy", 32'(bus.req1_ready), 32'd1);
    tick();
    set_req(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    wait_valid("post_abort");
    chk("post_abort_s",    32'(bus.s),      32'h0002);
    chk("post_abort_cout", 32'(bus.Cout),   32'd1);
    chk("post_abort_ovf",  32'(bus.ovf),    32'd0);
    chk("post_abort_id",   32'(bus.res_id), 32'd1);
    consume("post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
